// File: rtl/demod_audio_i2s.sv
// Demodulator audio back-end: AM/FM select, boxcar decimation to 16-bit PCM, mono Philips I2S out.
// Optional DC remover after the decimator is enabled by defining AUDIO_DC_BLOCK_EN.
module demod_audio_i2s #(
  parameter int INPUT_WIDTH = 12,
  parameter int DECIM_LOG2  = 11,
  parameter int BCLK_HALF   = 16,
  parameter int DC_SHIFT    = 10
) (
  input  logic                   clk_in,
  input  logic                   sys_rst_n,
  input  logic [INPUT_WIDTH-1:0] am_in,
  input  logic [INPUT_WIDTH-1:0] fm_in,
  input  logic                   src_sel,
  output logic [15:0]            sample_out,
  output logic                   sample_valid,
  output logic                   underrun,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata
);

  localparam int ACC_W = INPUT_WIDTH + DECIM_LOG2;
  localparam int SHIFT = ACC_W - 16;
  localparam int DIV_W = $clog2(BCLK_HALF);

  if (BCLK_HALF < 2 || DC_SHIFT < 1 || DECIM_LOG2 < 1) begin : g_bad_params
    $error("demod_audio_i2s: BCLK_HALF must be >= 2, DC_SHIFT and DECIM_LOG2 >= 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  logic                    sel_q;
  logic [DECIM_LOG2-1:0]   decim_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [15:0]      d_q;
  logic                    d_valid;

  logic                          eff_sel;
  logic [INPUT_WIDTH-1:0]        raw;
  logic signed [INPUT_WIDTH-1:0] x;
  logic signed [ACC_W-1:0]       x_ext;
  logic signed [ACC_W-1:0]       sum;
  logic signed [15:0]            d_next;
  logic                          window_last;

  // The first sample of a window uses the live select so a window never mixes sources.
  assign eff_sel     = (decim_cnt == '0) ? src_sel : sel_q;
  assign raw         = eff_sel ? fm_in : am_in;
  assign x           = {~raw[INPUT_WIDTH-1], raw[INPUT_WIDTH-2:0]};
  assign x_ext       = {{DECIM_LOG2{x[INPUT_WIDTH-1]}}, x};
  assign sum         = acc + x_ext;
  assign window_last = &decim_cnt;

  if (SHIFT >= 0) begin : g_shift_right
    assign d_next = 16'(sum >>> SHIFT);
  end else begin : g_shift_left
    assign d_next = 16'(sum) <<< (-SHIFT);
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      decim_cnt <= '0;
      acc       <= '0;
      sel_q     <= 1'b0;
      d_q       <= '0;
      d_valid   <= 1'b0;
    end else begin
      decim_cnt <= decim_cnt + 1'b1;
      d_valid   <= window_last;
      if (decim_cnt == '0) begin
        acc   <= x_ext;
        sel_q <= src_sel;
      end else begin
        acc <= sum;
      end
      if (window_last) d_q <= d_next;
    end
  end

`ifdef AUDIO_DC_BLOCK_EN
  localparam int M_W = 16 + DC_SHIFT;

  logic signed [M_W-1:0] m_acc;
  logic signed [15:0]    m;
  logic signed [16:0]    diff;
  logic [15:0]           y_sat;
  logic [15:0]           y_q;
  logic                  y_valid;

  assign m    = 16'(m_acc >>> DC_SHIFT);
  assign diff = $signed({d_q[15], d_q}) - $signed({m[15], m});

  always_comb begin
    y_sat = diff[15:0];
    if (diff > 17'sd32767)       y_sat = 16'h7FFF;
    else if (diff < -17'sd32768) y_sat = 16'h8000;
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_acc   <= '0;
      y_q     <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= d_valid;
      if (d_valid) begin
        y_q   <= y_sat;
        m_acc <= m_acc + {{(DC_SHIFT-1){diff[16]}}, diff};
      end
    end
  end

  assign sample_out   = y_q;
  assign sample_valid = y_valid;
`else
  assign sample_out   = d_q;
  assign sample_valid = d_valid;
`endif

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [15:0]      shift_word;
  logic [15:0]      hold;
  logic             fresh;

  logic       fall_tick;
  logic       frame_load;
  logic [5:0] next_bit;
  logic [4:0] slot_pos;
  logic       slot_bit;

  assign fall_tick  = (state == RUN) && (div_cnt == DIV_W'(BCLK_HALF - 1)) && i2s_bclk;
  assign next_bit   = bit_cnt + 6'd1;
  assign frame_load = fall_tick && (next_bit == 6'd0);
  assign slot_pos   = next_bit[4:0];
  assign slot_bit   = (slot_pos >= 5'd1 && slot_pos <= 5'd16) ?
                      shift_word[4'(5'd16 - slot_pos)] : 1'b0;

  // Holding register, frame sequencer and serialiser share one block so a load
  // coinciding with a new sample reads the old word and leaves fresh set.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_word <= '0;
      hold       <= '0;
      fresh      <= 1'b0;
      underrun   <= 1'b0;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_sdata  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (sample_valid) begin
        hold  <= sample_out;
        fresh <= 1'b1;
      end else if (frame_load) begin
        fresh <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sample_valid) begin
            state    <= RUN;
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
            bit_cnt  <= 6'd63;
          end
        end
        RUN: begin
          if (div_cnt == DIV_W'(BCLK_HALF - 1)) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
            if (i2s_bclk) begin
              bit_cnt   <= next_bit;
              i2s_lrck  <= next_bit[5];
              i2s_sdata <= slot_bit;
              if (next_bit == 6'd0) begin
                shift_word <= hold;
                underrun   <= ~fresh;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_audio_i2s.sv
// Bench for demod_audio_i2s: windowed stimulus table with a scoreboard of expected PCM words,
// I2S frame capture, a slow-rate instance for underrun, and a mid-frame reset sequence.
module tb_demod_audio_i2s;

`ifdef AUDIO_DC_BLOCK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_in = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] am_in = 12'h800;
  logic [11:0] fm_in = 12'h800;
  logic        src_sel = 1'b0;

  logic [15:0] sample_out, sample_out2;
  logic        sample_valid, sample_valid2;
  logic        underrun, underrun2;
  logic        i2s_bclk, i2s_lrck, i2s_sdata;
  logic        i2s_bclk2, i2s_lrck2, i2s_sdata2;

  demod_audio_i2s #(.INPUT_WIDTH(12), .DECIM_LOG2(11), .BCLK_HALF(16), .DC_SHIFT(10)) u_dut (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .am_in(am_in), .fm_in(fm_in), .src_sel(src_sel),
    .sample_out(sample_out), .sample_valid(sample_valid), .underrun(underrun),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata));

  demod_audio_i2s #(.INPUT_WIDTH(12), .DECIM_LOG2(12), .BCLK_HALF(16), .DC_SHIFT(10)) u_dut_slow (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .am_in(am_in), .fm_in(fm_in), .src_sel(src_sel),
    .sample_out(sample_out2), .sample_valid(sample_valid2), .underrun(underrun2),
    .i2s_bclk(i2s_bclk2), .i2s_lrck(i2s_lrck2), .i2s_sdata(i2s_sdata2));

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [11:0] am_a;
    logic [11:0] am_b;
    int          n_b;
    logic [11:0] fm;
    logic        sel0;
    int          toggle_at;
    logic [15:0] exp_d;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        running = 1'b0;
  logic        done = 1'b0;
  int          cyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef AUDIO_DC_BLOCK_EN
  logic signed [25:0] model_macc = '0;

  function automatic logic [15:0] dcModel(input logic [15:0] d);
    logic signed [15:0] m;
    logic signed [16:0] diff;
    logic [15:0]        y;
    m    = 16'(model_macc >>> 10);
    diff = $signed({d[15], d}) - $signed({m[15], m});
    if (diff > 17'sd32767)       y = 16'h7FFF;
    else if (diff < -17'sd32768) y = 16'h8000;
    else                         y = diff[15:0];
    model_macc = model_macc + 26'(diff);
    return y;
  endfunction
`endif

  // One full 2048-sample window; expected word is queued as the window starts.
  task automatic applyStimulus(input vec_t v);
`ifdef AUDIO_DC_BLOCK_EN
    sb_q.push_back(dcModel(v.exp_d));
`else
    sb_q.push_back(v.exp_d);
`endif
    for (int k = 0; k < 2048; k++) begin
      am_in   = (k < v.n_b) ? v.am_b : v.am_a;
      fm_in   = v.fm;
      src_sel = (v.toggle_at >= 0 && k >= v.toggle_at) ? ~v.sel0 : v.sel0;
      @(negedge clk_in);
    end
  endtask

  function automatic logic [63:0] buildFrame(input logic [15:0] w);
    logic [63:0] f;
    f = '0;
    for (int p = 1; p <= 16; p++) begin
      f[63-p]      = w[16-p];
      f[63-32-p]   = w[16-p];
    end
    return f;
  endfunction

  int          last_valid_cyc = -1;
  int          last_bclk_rise = -1;
  int          last_lrck_rise = -1;
  int          last_ur2 = -1;
  int          ur2_count = 0;
  int          ur1_count = 0;
  int          pos = -1;
  logic        prev_bclk = 1'b0;
  logic        prev_lrck = 1'b0;
  logic        prev_lrck_s = 1'b0;
  logic [15:0] last_exp = '0;
  logic [15:0] frame_exp = '0;
  logic [63:0] frame = '0;

  always begin
    @(posedge clk_in);
    #1;
    if (running && !done) begin
      cyc++;
      if (sample_valid) begin
        if (last_valid_cyc < 0) checkOutput("first_valid_cycle", 64'(cyc), 64'(2047 + LAT));
        else                    checkOutput("valid_spacing", 64'(cyc - last_valid_cyc), 64'd2048);
        last_valid_cyc = cyc;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_valid", 64'd1, 64'd0);
        end else begin
          last_exp = sb_q.pop_front();
          checkOutput("sample_out", 64'(sample_out), 64'(last_exp));
        end
      end
      if (i2s_bclk && !prev_bclk) begin
        if (last_bclk_rise >= 0) checkOutput("bclk_period", 64'(cyc - last_bclk_rise), 64'd32);
        last_bclk_rise = cyc;
        if (prev_lrck_s && !i2s_lrck) begin
          pos = 0;
          frame_exp = last_exp;
        end else if (pos >= 0) begin
          pos++;
        end
        if (pos >= 0) frame[63-pos] = i2s_sdata;
        if (pos == 63) begin
          checkOutput("i2s_frame", frame, buildFrame(frame_exp));
          pos = -1;
        end
        prev_lrck_s = i2s_lrck;
      end
      if (i2s_lrck && !prev_lrck) begin
        if (last_lrck_rise >= 0) checkOutput("lrck_period", 64'(cyc - last_lrck_rise), 64'd2048);
        last_lrck_rise = cyc;
      end
      prev_bclk = i2s_bclk;
      prev_lrck = i2s_lrck;
      if (underrun) ur1_count++;
      if (underrun2) begin
        if (last_ur2 < 0) checkOutput("slow_first_underrun", 64'(cyc), 64'(6176 + LAT));
        else              checkOutput("slow_underrun_spacing", 64'(cyc - last_ur2), 64'd4096);
        last_ur2 = cyc;
        ur2_count++;
      end
    end
  end

  initial begin
    vecs[0] = '{12'h800, 12'h800, 0,   12'h800, 1'b0, -1,   16'h0000};
    vecs[1] = '{12'h800, 12'h800, 0,   12'h800, 1'b0, -1,   16'h0000};
    vecs[2] = '{12'hFFF, 12'hFFF, 0,   12'h800, 1'b0, -1,   16'h7FF0};
    vecs[3] = '{12'h000, 12'h000, 0,   12'h800, 1'b0, -1,   16'h8000};
    vecs[4] = '{12'hFFF, 12'hFFF, 0,   12'h000, 1'b0, 1000, 16'h7FF0};
    vecs[5] = '{12'hFFF, 12'hFFF, 0,   12'h000, 1'b1, -1,   16'h8000};
    vecs[6] = '{12'h25C, 12'h25D, 384, 12'h800, 1'b0, -1,   16'hA5C3};
    vecs[7] = '{12'h25C, 12'h25D, 384, 12'h800, 1'b0, -1,   16'hA5C3};
    vecs[8] = '{12'h000, 12'h000, 0,   12'h900, 1'b1, -1,   16'h1000};
    vecs[9] = '{12'h800, 12'h800, 0,   12'h800, 1'b0, -1,   16'h0000};

    $display("[TB] start");
    repeat (3) @(negedge clk_in);
    checkOutput("reset_outputs",
                64'({sample_out, sample_valid, underrun, i2s_bclk, i2s_lrck, i2s_sdata,
                     sample_out2, sample_valid2, underrun2, i2s_bclk2, i2s_lrck2, i2s_sdata2}),
                64'd0);
    sys_rst_n = 1'b1;
    running   = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    repeat (3) @(posedge clk_in);
    #2;
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    checkOutput("fast_underrun_count", 64'(ur1_count), 64'd0);
    checkOutput("slow_underrun_count", 64'(ur2_count), 64'd4);
    done = 1'b1;

    // Mid-frame asynchronous reset: wait for bclk high, then drop reset between edges.
    for (int t = 0; t < 200 && !i2s_bclk; t++) @(posedge clk_in);
    checkOutput("bclk_high_before_reset", 64'(i2s_bclk), 64'd1);
    @(posedge clk_in);
    #3;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                64'({sample_out, sample_valid, underrun, i2s_bclk, i2s_lrck, i2s_sdata,
                     sample_out2, sample_valid2, underrun2, i2s_bclk2, i2s_lrck2, i2s_sdata2}),
                64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
